sseg_scan_decoder: RTL and testbench
====================================

Name: sseg_scan_decoder

Overview:
- Receive-side counterpart of the four-digit time-multiplexed seven-segment driver.
- Samples the multiplexed an/sseg/decimal bus and rebuilds the four digit patterns and decimal points.
- Checks that the digits are scanned in order 0→1→2→3 and publishes a complete frame once per valid scan.
- Used for display loopback self-test and as a capture monitor on the display bus.

Parameters:
SETTLE_CYCLES, 1, consecutive registered cycles an must hold one value before sseg/decimal are sampled (range 1-15).
TIMEOUT, 16, cycles without a capture, while not in HUNT, before scan_error fires (range 2-255).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
an  in  4  anode enables, active-low one-hot (1110=digit0 … 0111=digit3, 1111=blank)
sseg  in  7  segment pattern, active-low
decimal  in  1  decimal point, active-low
out0  out  7  captured digit0 pattern
out1  out  7  captured digit1 pattern
out2  out  7  captured digit2 pattern
out3  out  7  captured digit3 pattern
dp  out  4  captured decimal points, bit i = digit i
frame_valid  out  1  one-cycle pulse when out*/dp update
locked  out  1  high while in LOCKED
scan_error  out  1  one-cycle pulse on any scan violation

Behaviour:
- Reset, asynchronous on reset_n low: out0-3=7'h7F, dp=4'hF, frame_valid=0, scan_error=0, locked=0, state=HUNT, expect=0, staging=7'h7F/1, settle and timeout counters=0.
- Input stage: an, sseg, decimal are registered once (an_q, seg_q, dp_q). Everything else operates on the registered copies.
- Settle counter:
  - Resets to 1 on any cycle where an_q changes; otherwise increments, saturating.
  - A capture event fires exactly once per anode episode, on the cycle the counter equals SETTLE_CYCLES and an_q is a legal digit code.
  - At capture, seg_q and dp_q go into staging[digit].
- Decode of an_q:
  - 1110/1101/1011/0111 → digit 0-3.
  - 1111 → blank; no capture, not an error.
  - Any other code → illegal.
- FSM states: HUNT, TRACK, LOCKED.
  - HUNT: ignore captures of digits 1-3. Capture of digit0 → TRACK, expect=1.
  - TRACK and LOCKED, capture with digit==expect: expect increments (wraps 3→0).
  - Capture of digit3 in TRACK or LOCKED: on the same edge, staging plus the current sample are copied to out0-3/dp, frame_valid=1, state→LOCKED.
  - Capture with digit≠expect, digit0: scan_error pulse, restart with expect=1, state→TRACK.
  - Capture with digit≠expect, any other digit: scan_error pulse, state→HUNT.
  - Illegal an_q in any state: scan_error pulse, state→HUNT. Held illegal codes pulse only once, on entry.
  - Timeout counter clears on every capture. It counts in TRACK/LOCKED; reaching TIMEOUT → scan_error pulse, →HUNT.
- out*/dp are never cleared by errors. They hold the last good frame until the next frame or reset.
- Latency: new an value at the input → capture at edge 1+SETTLE_CYCLES. Digit3 capture → frame_valid on that same edge.
- Simultaneous illegal code and timeout: one scan_error pulse, HUNT.
- Reset mid-frame: staging is discarded; the next frame needs a fresh digit0.

Decomposition:
- Shared package sseg_pkg holds:
  - The state enum (HUNT/TRACK/LOCKED).
  - Anode code constants AN_D0..AN_D3 and AN_BLANK.
  - SEG_BLANK=7'h7F.
- These constants are shared with the display driver.
- One natural sub-module, sseg_settle_counter: the stability counter plus the once-per-episode capture strobe.

Test Plan:
- Drive the driver sequence 1110/1101/1011/0111 at SETTLE_CYCLES=1 with sseg=7'h40/7'h79/7'h24/7'h30 and decimal=1,1,0,1. Required: frame_valid on the 0111 capture edge, out0-3 = 40/79/24/30, dp=4'b1011, locked=1.
- Start the scan at 1011 (digit2). Required: no frame and no error until digit0 is seen; the first frame follows the next complete 0→3 scan.
- Locked, then inject order 0,1,3. Required: scan_error pulse, state HUNT, locked=0, out* unchanged.
- Apply an=1100 for 3 cycles. Required: exactly one scan_error pulse, HUNT.
- Locked, then hold an=1111 for 16 cycles (TIMEOUT=16). Required: scan_error pulse on the 16th cycle without a capture.
- Set SETTLE_CYCLES=3 and hold each digit 2 cycles. Required: no captures, then timeout error. Hold each digit 4 cycles: frames resume.
- Assert reset_n low mid-frame (after digit1). Required: out*=7F and dp=F immediately; after release, the first frame requires a full 0-3 scan.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared display-bus definitions: scan states, anode codes, blank segment pattern.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
package sseg_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Active-low one-hot anode codes, shared with the display driver
  localparam logic [3:0] AN_D0    = 4'b1110;
  localparam logic [3:0] AN_D1    = 4'b1101;
  localparam logic [3:0] AN_D2    = 4'b1011;
  localparam logic [3:0] AN_D3    = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       legal;   // one of the four digit codes
    logic       blank;   // all anodes off
    logic [1:0] digit;   // valid only when legal
  } an_dec_t;

  // Anything that is neither a digit code nor blank is illegal
  function automatic an_dec_t decode_an(input logic [3:0] an);
    an_dec_t d;
    d = '0;
    case (an)
      AN_D0:    begin d.legal = 1'b1; d.digit = 2'd0; end
      AN_D1:    begin d.legal = 1'b1; d.digit = 2'd1; end
      AN_D2:    begin d.legal = 1'b1; d.digit = 2'd2; end
      AN_D3:    begin d.legal = 1'b1; d.digit = 2'd3; end
      AN_BLANK: d.blank = 1'b1;
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// Multiplexed display bus plus the rebuilt-frame outputs of the scan decoder.
// Latency: n/a (wiring only).
// Backpressure: none; the display bus is a free-running broadcast.
interface sseg_scan_decoder_if;
  logic [3:0] an;
  logic [6:0] sseg;
  logic       decimal;
  logic [6:0] out0;
  logic [6:0] out1;
  logic [6:0] out2;
  logic [6:0] out3;
  logic [3:0] dp;
  logic       frame_valid;
  logic       locked;
  logic       scan_error;

  // Driver / bench side: drives the display bus, observes the captured frame
  modport master (
    output an, sseg, decimal,
    input  out0, out1, out2, out3, dp, frame_valid, locked, scan_error
  );

  // Decoder side
  modport slave (
    input  an, sseg, decimal,
    output out0, out1, out2, out3, dp, frame_valid, locked, scan_error
  );
endinterface

// File: rtl/sseg_settle_counter.sv
// Anode stability counter; emits one capture strobe per anode episode.
// Latency: strobe is combinational, SETTLE_CYCLES cycles into a stable an_q episode.
// Backpressure: none; observes every cycle.
module sseg_settle_counter
  import sseg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] an_q,
  input  logic       digit_ok,
  output logic       capture,
  output logic       an_changed
);

  logic [3:0] an_prev;
  logic [4:0] cnt;
  logic [4:0] cnt_next;

  assign an_changed = (an_q != an_prev);

  // Restart at 1 on a new anode value, else count up and stick at the top.
  // The ceiling is above any legal SETTLE_CYCLES so the match happens only once.
  always_comb begin
    cnt_next = cnt;
    if (an_changed)
      cnt_next = 5'd1;
    else if (cnt != 5'h1F)
      cnt_next = cnt + 5'd1;
  end

  assign capture = digit_ok && (cnt_next == 5'(SETTLE_CYCLES));

  // Track previous anode value and the running episode length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_prev <= AN_BLANK;
      cnt     <= 5'd0;
    end else begin
      an_prev <= an_q;
      cnt     <= cnt_next;
    end
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Rebuilds four digit patterns from a multiplexed 7-seg bus and checks 0..3 scan order.
// Latency: capture 1+SETTLE_CYCLES edges after an changes; frame on the digit3 capture edge.
// Backpressure: none; frame_valid/scan_error are single-cycle pulses.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int TIMEOUT       = 16
) (
  input logic             clk,
  input logic             reset_n,
  sseg_scan_decoder_if.slave bus
);

  localparam logic [1:0] HUNT   = ST_HUNT;
  localparam logic [1:0] TRACK  = ST_TRACK;
  localparam logic [1:0] LOCKED = ST_LOCKED;

  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;
  an_dec_t         an_dec;
  logic            capture;
  logic            an_changed;
  logic            illegal_entry;
  logic [1:0]      state;
  logic [1:0]      exp_dig;
  logic [7:0]      to_cnt;
  logic [3:0][6:0] stg_seg;
  logic [3:0]      stg_dp;
  logic [6:0]      out0_q, out1_q, out2_q, out3_q;
  logic [3:0]      dp_out_q;
  logic            frame_valid_q;
  logic            scan_error_q;

  // Register the raw bus once; all decisions use these copies
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= AN_BLANK;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= bus.an;
      seg_q <= bus.sseg;
      dp_q  <= bus.decimal;
    end
  end

  assign an_dec = decode_an(an_q);

  sseg_settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk        (clk),
    .reset_n    (reset_n),
    .an_q       (an_q),
    .digit_ok   (an_dec.legal),
    .capture    (capture),
    .an_changed (an_changed)
  );

  // An illegal code reports once, on the cycle it first appears
  assign illegal_entry = an_changed && !an_dec.legal && !an_dec.blank;

  // Stage every captured digit, whatever the scan state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_seg <= {4{SEG_BLANK}};
      stg_dp  <= 4'hF;
    end else if (capture) begin
      stg_seg[an_dec.digit] <= seg_q;
      stg_dp[an_dec.digit]  <= dp_q;
    end
  end

  // Scan-order FSM, timeout watchdog and frame publication
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HUNT;
      exp_dig       <= 2'd0;
      to_cnt        <= 8'd0;
      out0_q        <= SEG_BLANK;
      out1_q        <= SEG_BLANK;
      out2_q        <= SEG_BLANK;
      out3_q        <= SEG_BLANK;
      dp_out_q      <= 4'hF;
      frame_valid_q <= 1'b0;
      scan_error_q  <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      scan_error_q  <= 1'b0;
      if (illegal_entry) begin
        // Also absorbs a coincident timeout: still a single pulse
        scan_error_q <= 1'b1;
        state        <= HUNT;
        exp_dig      <= 2'd0;
        to_cnt       <= 8'd0;
      end else if (capture) begin
        to_cnt <= 8'd0;
        case (state)
          HUNT: begin
            if (an_dec.digit == 2'd0) begin
              state   <= TRACK;
              exp_dig <= 2'd1;
            end
          end
          default: begin
            if (an_dec.digit == exp_dig) begin
              exp_dig <= exp_dig + 2'd1;
              if (an_dec.digit == 2'd3) begin
                // Digit3 comes straight from the sample, not from staging
                out0_q        <= stg_seg[0];
                out1_q        <= stg_seg[1];
                out2_q        <= stg_seg[2];
                out3_q        <= seg_q;
                dp_out_q      <= {dp_q, stg_dp[2:0]};
                frame_valid_q <= 1'b1;
                state         <= LOCKED;
              end
            end else if (an_dec.digit == 2'd0) begin
              // Out-of-order digit0 still marks a scan start
              scan_error_q <= 1'b1;
              state        <= TRACK;
              exp_dig      <= 2'd1;
            end else begin
              scan_error_q <= 1'b1;
              state        <= HUNT;
              exp_dig      <= 2'd0;
            end
          end
        endcase
      end else if (state != HUNT) begin
        if (to_cnt + 8'd1 == 8'(TIMEOUT)) begin
          scan_error_q <= 1'b1;
          state        <= HUNT;
          exp_dig      <= 2'd0;
          to_cnt       <= 8'd0;
        end else begin
          to_cnt <= to_cnt + 8'd1;
        end
      end else begin
        to_cnt <= 8'd0;
      end
    end
  end

  assign bus.out0        = out0_q;
  assign bus.out1        = out1_q;
  assign bus.out2        = out2_q;
  assign bus.out3        = out3_q;
  assign bus.dp          = dp_out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.scan_error  = scan_error_q;
  assign bus.locked      = (state == LOCKED);

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench: two decoders (settle 1 and settle 3) share one display bus.
// Latency: n/a.
// Backpressure: n/a.
module tb_sseg_scan_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] an = 4'hF;
  logic [6:0] sseg = 7'h7F;
  logic       decimal = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;
  int nf1 = 0, ne1 = 0, nf3 = 0, ne3 = 0;

  always #5 clk = ~clk;

  sseg_scan_decoder_if bus1 ();
  sseg_scan_decoder_if bus3 ();

  assign bus1.an = an;
  assign bus1.sseg = sseg;
  assign bus1.decimal = decimal;
  assign bus3.an = an;
  assign bus3.sseg = sseg;
  assign bus3.decimal = decimal;

  sseg_scan_decoder #(.SETTLE_CYCLES(1), .TIMEOUT(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));
  sseg_scan_decoder #(.SETTLE_CYCLES(3), .TIMEOUT(16)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3));

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dec;
    int         hold;
    int         frames;
    int         errs;
    logic       lk;
    logic [6:0] o0, o1, o2, o3;
    logic [3:0] dp;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(input logic [3:0] a, input logic [6:0] s, input logic d,
                              input int h, input int f, input int e, input logic l,
                              input logic [6:0] o0, input logic [6:0] o1,
                              input logic [6:0] o2, input logic [6:0] o3,
                              input logic [3:0] p);
    vec_t v;
    v.an = a; v.seg = s; v.dec = d; v.hold = h; v.frames = f; v.errs = e; v.lk = l;
    v.o0 = o0; v.o1 = o1; v.o2 = o2; v.o3 = o3; v.dp = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock; outputs are sampled 1ns after the edge and pulses tallied
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus1.frame_valid) nf1++;
    if (bus1.scan_error)  ne1++;
    if (bus3.frame_valid) nf3++;
    if (bus3.scan_error)  ne3++;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int h);
    an = a; sseg = s; decimal = d;
    for (int k = 0; k < h; k++) tick();
  endtask

  task automatic clear_counts();
    nf1 = 0; ne1 = 0; nf3 = 0; ne3 = 0;
  endtask

  localparam logic [6:0] BL = 7'h7F;

  initial begin
    // Frame A: 40/79/24/30 dp 1011; frame B: 06/5B/4F/66 dp 0110
    tbl[0]  = mk(4'hB, 7'h24, 1'b0,  2, 0, 0, 1'b0, BL, BL, BL, BL, 4'hF);
    tbl[1]  = mk(4'h7, 7'h30, 1'b1,  2, 0, 0, 1'b0, BL, BL, BL, BL, 4'hF);
    tbl[2]  = mk(4'hE, 7'h40, 1'b1,  2, 0, 0, 1'b0, BL, BL, BL, BL, 4'hF);
    tbl[3]  = mk(4'hD, 7'h79, 1'b1,  2, 0, 0, 1'b0, BL, BL, BL, BL, 4'hF);
    tbl[4]  = mk(4'hB, 7'h24, 1'b0,  2, 0, 0, 1'b0, BL, BL, BL, BL, 4'hF);
    tbl[5]  = mk(4'h7, 7'h30, 1'b1,  2, 1, 0, 1'b1, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[6]  = mk(4'hE, 7'h06, 1'b0,  2, 1, 0, 1'b1, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[7]  = mk(4'hD, 7'h5B, 1'b1,  2, 1, 0, 1'b1, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[8]  = mk(4'hB, 7'h4F, 1'b1,  2, 1, 0, 1'b1, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[9]  = mk(4'h7, 7'h66, 1'b0,  2, 2, 0, 1'b1, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h6);
    tbl[10] = mk(4'hE, 7'h40, 1'b1,  2, 2, 0, 1'b1, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h6);
    tbl[11] = mk(4'hD, 7'h79, 1'b1,  2, 2, 0, 1'b1, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h6);
    tbl[12] = mk(4'h7, 7'h30, 1'b1,  2, 2, 1, 1'b0, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h6);
    tbl[13] = mk(4'hC, 7'h00, 1'b1,  3, 2, 2, 1'b0, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h6);
    tbl[14] = mk(4'hE, 7'h40, 1'b1,  2, 2, 2, 1'b0, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h6);
    tbl[15] = mk(4'hD, 7'h79, 1'b1,  2, 2, 2, 1'b0, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h6);
    tbl[16] = mk(4'hB, 7'h24, 1'b0,  2, 2, 2, 1'b0, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h6);
    tbl[17] = mk(4'h7, 7'h30, 1'b1,  2, 3, 2, 1'b1, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[18] = mk(4'hF, 7'h7F, 1'b1, 15, 3, 2, 1'b1, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[19] = mk(4'hF, 7'h7F, 1'b1,  1, 3, 3, 1'b0, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[20] = mk(4'hE, 7'h40, 1'b1,  2, 3, 3, 1'b0, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[21] = mk(4'hD, 7'h79, 1'b1,  2, 3, 3, 1'b0, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[22] = mk(4'hE, 7'h06, 1'b0,  2, 3, 4, 1'b0, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[23] = mk(4'hD, 7'h5B, 1'b1,  2, 3, 4, 1'b0, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[24] = mk(4'hB, 7'h4F, 1'b1,  2, 3, 4, 1'b0, 7'h40, 7'h79, 7'h24, 7'h30, 4'hB);
    tbl[25] = mk(4'h7, 7'h66, 1'b0,  2, 4, 4, 1'b1, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h6);

    // Reset state
    tick();
    chk("rst out0", 32'(bus1.out0), 32'h7F);
    chk("rst out3", 32'(bus1.out3), 32'h7F);
    chk("rst dp", 32'(bus1.dp), 32'hF);
    chk("rst frame_valid", 32'(bus1.frame_valid), 32'h0);
    chk("rst scan_error", 32'(bus1.scan_error), 32'h0);
    chk("rst locked", 32'(bus1.locked), 32'h0);
    reset_n = 1'b1;
    clear_counts();

    // Table: late start, normal frames, order error, illegal code, timeout, digit0 restart
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].an, tbl[i].seg, tbl[i].dec, tbl[i].hold);
      chk($sformatf("row%0d frames", i), 32'(nf1), 32'(tbl[i].frames));
      chk($sformatf("row%0d errors", i), 32'(ne1), 32'(tbl[i].errs));
      chk($sformatf("row%0d locked", i), 32'(bus1.locked), 32'(tbl[i].lk));
      chk($sformatf("row%0d out0", i), 32'(bus1.out0), 32'(tbl[i].o0));
      chk($sformatf("row%0d out1", i), 32'(bus1.out1), 32'(tbl[i].o1));
      chk($sformatf("row%0d out2", i), 32'(bus1.out2), 32'(tbl[i].o2));
      chk($sformatf("row%0d out3", i), 32'(bus1.out3), 32'(tbl[i].o3));
      chk($sformatf("row%0d dp", i), 32'(bus1.dp), 32'(tbl[i].dp));
    end

    // Reset mid-frame, after digit1 has been captured
    drive(4'hE, 7'h40, 1'b1, 2);
    drive(4'hD, 7'h79, 1'b1, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst out0", 32'(bus1.out0), 32'h7F);
    chk("midrst out2", 32'(bus1.out2), 32'h7F);
    chk("midrst dp", 32'(bus1.dp), 32'hF);
    chk("midrst locked", 32'(bus1.locked), 32'h0);
    an = 4'hF; sseg = 7'h7F; decimal = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    clear_counts();
    drive(4'hD, 7'h79, 1'b1, 2);
    drive(4'hB, 7'h24, 1'b0, 2);
    drive(4'h7, 7'h30, 1'b1, 2);
    chk("postrst partial frames", 32'(nf1), 32'h0);
    chk("postrst partial errors", 32'(ne1), 32'h0);
    chk("postrst partial locked", 32'(bus1.locked), 32'h0);
    // Full scan, one cycle per digit: frame_valid lands one edge after an_q=0111
    drive(4'hE, 7'h40, 1'b1, 1);
    drive(4'hD, 7'h79, 1'b1, 1);
    drive(4'hB, 7'h24, 1'b0, 1);
    drive(4'h7, 7'h30, 1'b1, 1);
    chk("lat pre frame_valid", 32'(bus1.frame_valid), 32'h0);
    drive(4'hF, 7'h7F, 1'b1, 1);
    chk("lat frame_valid", 32'(bus1.frame_valid), 32'h1);
    chk("lat out0", 32'(bus1.out0), 32'h40);
    chk("lat out1", 32'(bus1.out1), 32'h79);
    chk("lat out3", 32'(bus1.out3), 32'h30);
    chk("lat dp", 32'(bus1.dp), 32'hB);
    chk("lat locked", 32'(bus1.locked), 32'h1);
    tick();
    chk("lat post frame_valid", 32'(bus1.frame_valid), 32'h0);
    chk("lat frames", 32'(nf1), 32'h1);

    // Settle window of 3: short holds never capture, long holds do
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    clear_counts();
    drive(4'hE, 7'h40, 1'b1, 4);
    drive(4'hD, 7'h79, 1'b1, 4);
    drive(4'hB, 7'h24, 1'b0, 4);
    drive(4'h7, 7'h30, 1'b1, 4);
    chk("s3 first frames", 32'(nf3), 32'h1);
    chk("s3 first locked", 32'(bus3.locked), 32'h1);
    chk("s3 first out0", 32'(bus3.out0), 32'h40);
    chk("s3 first out2", 32'(bus3.out2), 32'h24);
    chk("s3 first dp", 32'(bus3.dp), 32'hB);
    for (int r = 0; r < 7; r++)
      drive(r[1:0] == 2'd0 ? 4'hE : r[1:0] == 2'd1 ? 4'hD : r[1:0] == 2'd2 ? 4'hB : 4'h7,
            7'h11, 1'b1, 2);
    chk("s3 short no error yet", 32'(ne3), 32'h0);
    chk("s3 short still locked", 32'(bus3.locked), 32'h1);
    drive(4'h7, 7'h11, 1'b1, 2);
    chk("s3 timeout errors", 32'(ne3), 32'h1);
    chk("s3 timeout frames", 32'(nf3), 32'h1);
    chk("s3 timeout locked", 32'(bus3.locked), 32'h0);
    chk("s3 timeout out3 held", 32'(bus3.out3), 32'h30);
    drive(4'hE, 7'h06, 1'b0, 4);
    drive(4'hD, 7'h5B, 1'b1, 4);
    drive(4'hB, 7'h4F, 1'b1, 4);
    drive(4'h7, 7'h66, 1'b0, 4);
    chk("s3 resume frames", 32'(nf3), 32'h2);
    chk("s3 resume errors", 32'(ne3), 32'h1);
    chk("s3 resume locked", 32'(bus3.locked), 32'h1);
    chk("s3 resume out1", 32'(bus3.out1), 32'h5B);
    chk("s3 resume dp", 32'(bus3.dp), 32'h6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
